cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
Fetch/execute sequencer for the CPU core. It generates the 2-bit `state` bus consumed by the instruction decoder (fetch, exec1, exec2) and gates the fetch-side enables: PC count and IR load. It also handles instruction-memory wait states, halting on STP, and interrupt entry between instructions. A retired-instruction counter is kept for debug.

Parameters:
CNT_W, 16, width of the retired-instruction counter
IRQ_VECTOR, 16'h0004, PC value loaded on interrupt entry

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
sm_extra  input  1  from decoder; current instruction needs exec2 (valid in exec1)
stp  input  1  from decoder; current instruction is STP (valid in exec1)
mem_ready  input  1  instruction RAM read data valid this cycle
irq  input  1  level interrupt request
int_en  input  1  interrupt enable flag from status register
resume  input  1  leave HALT (debug/run pin)
state  output  2  to decoder: 00 fetch, 10 exec1, 01 exec2, 11 halt/irq (decoder idle)
ir_en  output  1  load instruction register
pc_cnt_en  output  1  increment PC
irq_pc_sload  output  1  load PC with irq_vector
irq_vector  output  16  constant IRQ_VECTOR
irq_ack  output  1  one-cycle acknowledge of accepted interrupt
halted  output  1  high while in HALT
retired  output  CNT_W  count of completed instructions

Behaviour:
- Internal states: FETCH, EXEC1, EXEC2, HALT, IRQ. Output `state` encoding:
  - FETCH=00, EXEC1=10, EXEC2=01.
  - HALT=11 and IRQ=11. The decoder decodes neither as an action.
- Reset (rst_n low, asynchronous): enter FETCH.
  - state=00, retired=0, halted=0.
  - ir_en, pc_cnt_en, irq_pc_sload and irq_ack are 0 (all combinational outputs are qualified off while rst_n is low).
- FETCH:
  - ir_en=pc_cnt_en=mem_ready (combinational).
  - If mem_ready=0, stay in FETCH (wait state); no PC or IR change.
  - If mem_ready=1, go to EXEC1 next cycle.
- EXEC1, evaluated in priority order:
  - stp=1 -> HALT. Retired increments; STP counts as retired.
  - Else sm_extra=1 -> EXEC2.
  - Else the instruction ends. Go to IRQ if (irq & int_en), else FETCH. Retired increments.
- EXEC2:
  - Always one cycle. The instruction ends and retired increments.
  - Next state is IRQ if (irq & int_en), else FETCH.
- IRQ:
  - Exactly one cycle. irq_ack=1 and irq_pc_sload=1; ir_en and pc_cnt_en stay 0.
  - Next state is FETCH.
  - Interrupts are sampled only at instruction end, never in FETCH or mid-instruction.
  - irq_ack does not clear irq; the source drops irq or firmware clears int_en.
- HALT:
  - halted=1; all enables 0.
  - resume=1 -> FETCH next cycle.
  - An interrupt also exits HALT: if irq & int_en while halted, go to IRQ, with priority over resume.
- Simultaneous events: if stp and sm_extra are both set, stp wins. If stp is set and an interrupt is pending, HALT is entered first and the interrupt is then taken from HALT.
- retired wraps modulo 2^CNT_W with no saturation. It increments exactly once per instruction, in the cycle that leaves EXEC1 or EXEC2 toward FETCH, IRQ or HALT.
- Reset mid-instruction or mid-wait aborts immediately to FETCH with outputs at reset values; no partial retire is counted.
- Illegal internal state encodings recover to FETCH on the next clock.

Test Plan:
- Reset then mem_ready=1 constantly, sm_extra=0 -> state sequence 00,10,00,10,…; ir_en/pc_cnt_en high every FETCH; retired = 3 after 6 cycles.
- Instruction with sm_extra=1 in exec1 -> 00,10,01,00; retired increments at EXEC2 exit only.
- mem_ready=0 for 3 cycles in FETCH -> state holds 00 for 4 cycles; ir_en=0 until the mem_ready cycle; PC increments once.
- stp=1 in exec1 -> state 11, halted=1, retired+1, no enables. Hold 5 cycles, then resume=1 -> returns to 00 next cycle.
- irq=1, int_en=1 asserted during exec1 of a non-extra instruction -> next state IRQ: irq_ack=1, irq_pc_sload=1, irq_vector=16'h0004, then FETCH. Same test with int_en=0 -> no IRQ cycle.
- Preset retired to 16'hFFFF (run 65535 instructions or force), retire one more -> retired=0. Assert rst_n low during EXEC2 -> asynchronous return to state 00, retired=0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer for the CPU core.
//
// Drives the 2-bit decoder state bus (fetch/exec1/exec2/idle), gates the
// fetch-side enables (IR load, PC count), inserts instruction-memory wait
// states, halts on STP, and enters interrupts between instructions. A
// retired-instruction counter is kept for debug.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   sm_extra_i     decoder: instruction needs exec2 (valid in exec1)
//   stp_i          decoder: instruction is STP (valid in exec1)
//   mem_ready_i    instruction RAM read data valid this cycle
//   irq_i          level interrupt request
//   int_en_i       interrupt enable from status register
//   resume_i       leave HALT
//   state_o        00 fetch, 10 exec1, 01 exec2, 11 halt/irq
//   ir_en_o        load instruction register
//   pc_cnt_en_o    increment PC
//   irq_pc_sload_o load PC with irq_vector_o
//   irq_vector_o   constant IRQ_VECTOR
//   irq_ack_o      one-cycle acknowledge of accepted interrupt
//   halted_o       high while in HALT
//   retired_o      count of completed instructions (wraps)
module cpu_sequencer #(
    parameter int unsigned CNT_W      = 16,
    parameter logic [15:0] IRQ_VECTOR = 16'h0004
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sm_extra_i,
    input  logic             stp_i,
    input  logic             mem_ready_i,
    input  logic             irq_i,
    input  logic             int_en_i,
    input  logic             resume_i,
    output logic [1:0]       state_o,
    output logic             ir_en_o,
    output logic             pc_cnt_en_o,
    output logic             irq_pc_sload_o,
    output logic [15:0]      irq_vector_o,
    output logic             irq_ack_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [2:0] {
        StFetch = 3'd0,
        StExec1 = 3'd1,
        StExec2 = 3'd2,
        StHalt  = 3'd3,
        StIrq   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       retire;
    logic       irq_take;
    logic [1:0] st_enc;
    logic       ir_en, pc_cnt_en, irq_sload, irq_ack, halted;

    assign irq_take = irq_i & int_en_i;

    always_comb begin
        state_d   = StFetch;
        retire    = 1'b0;
        st_enc    = 2'b00;
        ir_en     = 1'b0;
        pc_cnt_en = 1'b0;
        irq_sload = 1'b0;
        irq_ack   = 1'b0;
        halted    = 1'b0;
        case (state_q)
            StFetch: begin
                st_enc    = 2'b00;
                ir_en     = mem_ready_i;
                pc_cnt_en = mem_ready_i;
                state_d   = mem_ready_i ? StExec1 : StFetch;
            end
            StExec1: begin
                st_enc = 2'b10;
                if (stp_i) begin
                    // STP counts as retired; a pending irq is taken from HALT.
                    retire  = 1'b1;
                    state_d = StHalt;
                end else if (sm_extra_i) begin
                    state_d = StExec2;
                end else begin
                    retire  = 1'b1;
                    state_d = irq_take ? StIrq : StFetch;
                end
            end
            StExec2: begin
                st_enc  = 2'b01;
                retire  = 1'b1;
                state_d = irq_take ? StIrq : StFetch;
            end
            StHalt: begin
                st_enc = 2'b11;
                halted = 1'b1;
                // Interrupt has priority over resume.
                if (irq_take) begin
                    state_d = StIrq;
                end else if (resume_i) begin
                    state_d = StFetch;
                end else begin
                    state_d = StHalt;
                end
            end
            StIrq: begin
                st_enc    = 2'b11;
                irq_sload = 1'b1;
                irq_ack   = 1'b1;
                state_d   = StFetch;
            end
            default: begin
                // Illegal encodings recover to fetch.
                st_enc  = 2'b00;
                state_d = StFetch;
            end
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Combinational outputs are forced off while reset is asserted.
    assign state_o        = rst_ni ? st_enc : 2'b00;
    assign ir_en_o        = rst_ni & ir_en;
    assign pc_cnt_en_o    = rst_ni & pc_cnt_en;
    assign irq_pc_sload_o = rst_ni & irq_sload;
    assign irq_ack_o      = rst_ni & irq_ack;
    assign halted_o       = rst_ni & halted;
    assign irq_vector_o   = IRQ_VECTOR;
    assign retired_o      = retired_q;

endmodule
